// File: rtl/sprite_pkg.sv
// Definitions shared by the keyboard front end and the sprite mover:
// the four movement key codes and the key repeat state encoding.
package sprite_pkg;

    localparam logic [7:0] KEY_NONE  = 8'h00;
    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h07;
    localparam logic [7:0] KEY_DOWN  = 8'h16;
    localparam logic [7:0] KEY_UP    = 8'h1A;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } key_state_t;

endpackage

// File: rtl/key_repeat_gen.sv
// Turns a held HID keycode into single-frame step commands: one step on press,
// then one after DELAY_FRAMES and every REPEAT_FRAMES while the key stays down.
module key_repeat_gen
    import sprite_pkg::*;
#(
    parameter int DELAY_FRAMES  = 20,
    parameter int REPEAT_FRAMES = 4
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode_in,
    output logic [7:0] keycode_out,
    output logic       key_held,
    output logic       repeat_active
);

    localparam logic [5:0] DELAY_LAST  = 6'(DELAY_FRAMES - 1);
    localparam logic [5:0] REPEAT_LAST = 6'(REPEAT_FRAMES - 1);

    // Anything other than the four movement keys behaves as "no key".
    function automatic logic [7:0] filter_key(input logic [7:0] code);
        case (code)
            KEY_LEFT, KEY_RIGHT, KEY_DOWN, KEY_UP: filter_key = code;
            default:                               filter_key = KEY_NONE;
        endcase
    endfunction

    key_state_t state_reg, state_next;
    logic [7:0] key_reg, key_next;
    logic [5:0] cnt_reg, cnt_next;
    logic [7:0] out_next;
    logic [7:0] key_k;
    logic [5:0] cnt_last;

    assign key_k    = filter_key(keycode_in);
    assign cnt_last = (state_reg == ST_REPEAT) ? REPEAT_LAST : DELAY_LAST;

    always_comb begin
        state_next = state_reg;
        key_next   = key_reg;
        cnt_next   = cnt_reg;
        out_next   = KEY_NONE;
        case (state_reg)
            ST_IDLE: begin
                if (key_k != KEY_NONE) begin
                    key_next   = key_k;
                    out_next   = key_k;
                    cnt_next   = 6'd0;
                    state_next = ST_DELAY;
                end
            end
            ST_DELAY, ST_REPEAT: begin
                if (key_k == KEY_NONE) begin
                    cnt_next   = 6'd0;
                    state_next = ST_IDLE;
                end else if (key_k != key_reg) begin
                    // A different key restarts the full initial delay.
                    key_next   = key_k;
                    out_next   = key_k;
                    cnt_next   = 6'd0;
                    state_next = ST_DELAY;
                end else if (cnt_reg == cnt_last) begin
                    out_next   = key_reg;
                    cnt_next   = 6'd0;
                    state_next = ST_REPEAT;
                end else begin
                    cnt_next   = cnt_reg + 6'd1;
                end
            end
            default: begin
                cnt_next   = 6'd0;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_reg     <= ST_IDLE;
            key_reg       <= KEY_NONE;
            cnt_reg       <= 6'd0;
            keycode_out   <= KEY_NONE;
            key_held      <= 1'b0;
            repeat_active <= 1'b0;
        end else begin
            state_reg     <= state_next;
            key_reg       <= key_next;
            cnt_reg       <= cnt_next;
            keycode_out   <= out_next;
            key_held      <= (state_next != ST_IDLE);
            repeat_active <= (state_next == ST_REPEAT);
        end
    end

endmodule

// File: tb/tb_key_repeat_gen.sv
// Scoreboard bench for key_repeat_gen: a frames-since-press model predicts each
// edge's outputs, queued at drive time and compared after the edge.
module tb_key_repeat_gen;

    localparam int D = 20;
    localparam int R = 4;

    logic       frame_clk = 1'b0;
    logic       Reset     = 1'b1;
    logic [7:0] keycode_in = 8'h00;
    logic [7:0] keycode_out;
    logic       key_held;
    logic       repeat_active;

    typedef struct packed {
        logic [7:0] out;
        logic       held;
        logic       rep;
    } exp_t;

    exp_t sb_q[$];

    int total = 0;
    int bad   = 0;
    int step_no = 0;

    // Model state: latched key, whether a key is down, frames since press.
    logic [7:0] m_key  = 8'h00;
    logic       m_held = 1'b0;
    int         m_e    = 0;

    key_repeat_gen #(.DELAY_FRAMES(D), .REPEAT_FRAMES(R)) dut (
        .frame_clk     (frame_clk),
        .Reset         (Reset),
        .keycode_in    (keycode_in),
        .keycode_out   (keycode_out),
        .key_held      (key_held),
        .repeat_active (repeat_active)
    );

    always #5 frame_clk = ~frame_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] valid_key(input logic [7:0] code);
        if (code == 8'h04 || code == 8'h07 || code == 8'h16 || code == 8'h1A)
            return code;
        return 8'h00;
    endfunction

    // Drive one frame, predict the post-edge outputs, compare after the edge.
    task automatic step(input logic [7:0] k, input logic rst);
        exp_t e;
        logic [7:0] kf;
        keycode_in = k;
        Reset      = rst;
        kf = valid_key(k);
        if (rst) begin
            m_held = 1'b0; m_key = 8'h00; m_e = 0;
            e = '{out: 8'h00, held: 1'b0, rep: 1'b0};
        end else if (kf == 8'h00) begin
            m_held = 1'b0;
            e = '{out: 8'h00, held: 1'b0, rep: 1'b0};
        end else if (!m_held || kf != m_key) begin
            m_held = 1'b1; m_key = kf; m_e = 0;
            e = '{out: kf, held: 1'b1, rep: 1'b0};
        end else begin
            m_e++;
            e.held = 1'b1;
            e.rep  = (m_e >= D);
            e.out  = (m_e >= D && ((m_e - D) % R) == 0) ? kf : 8'h00;
        end
        sb_q.push_back(e);
        @(posedge frame_clk);
        #1;
        e = sb_q.pop_front();
        step_no++;
        $display("step %0d in=%02h rst=%0b out=%02h held=%0b rep=%0b", step_no, k, rst,
                 keycode_out, key_held, repeat_active);
        check_val("keycode_out", {24'd0, keycode_out}, {24'd0, e.out});
        check_val("key_held", {31'd0, key_held}, {31'd0, e.held});
        check_val("repeat_active", {31'd0, repeat_active}, {31'd0, e.rep});
    endtask

    initial begin
        #2;
        check_val("reset_out", {24'd0, keycode_out}, 32'd0);
        check_val("reset_held", {31'd0, key_held}, 32'd0);
        repeat (2) step(8'h04, 1'b1);
        repeat (2) step(8'h00, 1'b0);

        // Tap
        step(8'h04, 1'b0);
        repeat (3) step(8'h00, 1'b0);

        // Hold through delay and several repeats
        repeat (30) step(8'h07, 1'b0);
        repeat (2) step(8'h00, 1'b0);

        // Key change during delay restarts the delay
        repeat (10) step(8'h16, 1'b0);
        repeat (25) step(8'h1A, 1'b0);
        step(8'h00, 1'b0);

        // Invalid key never latches
        repeat (50) step(8'h2C, 1'b0);
        step(8'h00, 1'b0);

        // Release and re-press, then key change during repeat
        step(8'h04, 1'b0);
        step(8'h00, 1'b0);
        repeat (23) step(8'h04, 1'b0);
        repeat (6) step(8'h07, 1'b0);
        step(8'h00, 1'b0);

        // Asynchronous reset mid-repeat with the key still held
        repeat (22) step(8'h04, 1'b0);
        Reset = 1'b1;
        #1;
        check_val("async_rst_out", {24'd0, keycode_out}, 32'd0);
        check_val("async_rst_held", {31'd0, key_held}, 32'd0);
        check_val("async_rst_rep", {31'd0, repeat_active}, 32'd0);
        step(8'h04, 1'b1);
        repeat (22) step(8'h04, 1'b0);
        step(8'h00, 1'b0);

        check_val("sb_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
